reg_pipe: RTL

//  Parametrised elastic register pipeline: WIDTH-bit data carried through DEPTH registered stages.

---
 rtl/reg_pipe.sv | 103 ++++++++++
 1 files changed

// File: rtl/reg_pipe.sv
// Elastic register pipeline: DEPTH valid/ready stages of WIDTH-bit data, bubbles
// collapse under a downstream stall, with global clock enable and synchronous flush.

module reg_pipe_stage #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             flush,
  input  logic             load,
  input  logic             adv,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] d,
  output logic             v
);
  // Flush clears the valid flag only; the data register keeps its contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= 1'b0;
      d <= '0;
    end else if (flush) begin
      v <= 1'b0;
    end else if (ce) begin
      if (load) begin
        v <= 1'b1;
        d <= din;
      end else begin
        v <= v & ~adv;
      end
    end
  end
endmodule

module reg_pipe #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);
  logic [DEPTH-1:0][WIDTH-1:0] d;
  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0]            adv;
  logic                        in_xfer, out_xfer;

  // A stage advances when it holds data and the stage ahead is empty or also advancing.
  // Walked from the output back with a scalar carry so the vector is write-only here.
  always_comb begin
    logic a;
    adv          = '0;
    a            = v[DEPTH-1] & out_ready;
    adv[DEPTH-1] = a;
    for (int i = DEPTH-2; i >= 0; i--) begin
      a      = v[i] & (~v[i+1] | a);
      adv[i] = a;
    end
  end

  assign in_ready  = ce & ~flush & (~v[0] | adv[0]);
  assign out_valid = v[DEPTH-1] & ce & ~flush;
  assign out_data  = d[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    if (i == 0) begin : g_head
      reg_pipe_stage #(.WIDTH(WIDTH)) u_stg (
        .clk(clk), .rst_n(rst_n), .ce(ce), .flush(flush),
        .load(in_xfer), .adv(adv[0]), .din(in_data),
        .d(d[0]), .v(v[0])
      );
    end else begin : g_body
      reg_pipe_stage #(.WIDTH(WIDTH)) u_stg (
        .clk(clk), .rst_n(rst_n), .ce(ce), .flush(flush),
        .load(adv[i-1]), .adv(adv[i]), .din(d[i-1]),
        .d(d[i]), .v(v[i])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      count <= '0;
    end else if (ce) begin
      case ({in_xfer, out_xfer})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule
